// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the shared pipeline ALU
// through a request/grant handshake; yields the low 32 bits of a*b.
module alu_mul_seq #(
  parameter int          N_BITS = 32,
  parameter logic [3:0]  ADD_OP = 4'b0000,
  parameter logic [3:0]  SLL_OP = 4'b0011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_s
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SHL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // ALU-facing outputs depend on registered state only, never on alu_gnt.
  always_comb begin
    alu_req  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = '0;
    case (state_q)
      S_ADD: begin
        alu_req  = 1'b1;
        alu_a    = acc_q;
        alu_b    = mcand_q;
        alu_aluc = ADD_OP;
      end
      S_SHL: begin
        alu_req  = 1'b1;
        alu_a    = 32'd1;
        alu_b    = mcand_q;
        alu_aluc = SLL_OP;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a_in;
          mplier_d = b_in;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        if (alu_gnt) begin
          if (mplier_q[0]) acc_d = alu_s;
          state_d = S_SHL;
        end
      end
      S_SHL: begin
        if (alu_gnt) begin
          mcand_d  = alu_s;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = acc_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU + arbiter, expected products queued
// at issue time and checked by an independent monitor on each done pulse.
module tb_alu_mul_seq;

  localparam int N_BITS  = 32;
  localparam int LAT     = 2 * N_BITS + 1;
  localparam int N_RAND  = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        busy, done, alu_req;
  logic        alu_gnt = 1'b1;
  logic [31:0] product, alu_a, alu_b, alu_s;
  logic [3:0]  alu_aluc;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  int  gnt_mode = 0;      // 0: always grant, 1: random grant
  int  stall_budget = 0;  // forced grant-low request cycles still to insert

  alu_mul_seq #(.N_BITS(N_BITS)) dut (
    .clock(clock), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_aluc(alu_aluc), .alu_s(alu_s)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0011: return b << a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mul_ref(logic [31:0] a, logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  assign alu_s = alu_model(alu_a, alu_b, alu_aluc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Arbiter: grant changes just after the rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (stall_budget > 0 && alu_req && $urandom_range(0, 1) == 1) begin
        alu_gnt = 1'b0;
        stall_budget--;
      end else if (gnt_mode == 1) begin
        alu_gnt = ($urandom_range(0, 15) != 0);
      end else begin
        alu_gnt = 1'b1;
      end
    end
  end

  // Monitor: samples on the falling edge, between input changes and the next sampling edge.
  initial begin
    bit          accept_pend = 0, inflight = 0, busy_chk = 0, stall_chk = 0;
    int          cyc = 0, stalls = 0;
    logic [31:0] sv_a, sv_b, exp_p;
    logic [3:0]  sv_op;
    forever begin
      @(negedge clock);
      if (reset) begin
        accept_pend = 0; inflight = 0; busy_chk = 0; stall_chk = 0;
        sb.delete();
      end else begin
        if (stall_chk) begin
          chk("stall_hold_a", alu_a, sv_a);
          chk("stall_hold_b", alu_b, sv_b);
          chk("stall_hold_op", {28'd0, alu_aluc}, {28'd0, sv_op});
          stall_chk = 0;
        end
        if (busy_chk) begin
          chk("busy_after_done", {31'd0, busy}, 32'd0);
          busy_chk = 0;
        end
        if (accept_pend) begin
          inflight = 1; cyc = 1; stalls = 0;
        end else if (inflight) begin
          cyc++;
        end
        accept_pend = 0;
        if (done) begin
          if (!inflight || sb.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            exp_p = sb.pop_front();
            chk("product", product, exp_p);
            chk("latency", cyc, LAT + stalls);
            busy_chk = 1;
          end
          inflight = 0;
        end
        if (inflight && alu_req && !alu_gnt) begin
          stalls++;
          stall_chk = 1;
          sv_a = alu_a; sv_b = alu_b; sv_op = alu_aluc;
        end
        if (start && !busy) accept_pend = 1;
      end
    end
  end

  // Issue an operation once the sequencer is idle; returns in cycle 1 of it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clock); #1;
    while (busy && n < 3000) begin
      @(posedge clock); #1; n++;
    end
    if (busy) chk("issue_timeout", {31'd0, busy}, 32'd0);
    start = 1'b1; a_in = a; b_in = b;
    sb.push_back(mul_ref(a, b));
    @(posedge clock); #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(posedge clock); #1; n++;
    end
    if (sb.size() != 0 || busy) chk("wait_timeout", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_req", {31'd0, alu_req}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_aluc", {28'd0, alu_aluc}, 32'd0);

    issue(32'd7, 32'd6);
    wait_idle();
    chk("basic_42", product, 32'd42);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("wrap_ones", product, 32'h0000_0001);
    issue(32'h0001_0000, 32'h0001_0000);
    wait_idle();
    chk("wrap_zero", product, 32'h0000_0000);
    issue(32'hFFFF_FFFD, 32'd5);
    wait_idle();
    chk("signed_neg3x5", product, 32'hFFFF_FFF1);
    repeat (5) @(posedge clock);
    #1 chk("product_holds", product, 32'hFFFF_FFF1);

    stall_budget = 10;
    issue(32'd7, 32'd6);
    wait_idle();
    chk("stall_42", product, 32'd42);
    chk("stall_all_used", stall_budget, 0);
    stall_budget = 0;

    issue(32'd3, 32'd4);
    repeat (19) @(posedge clock);
    #1;
    start = 1'b1; a_in = 32'd9; b_in = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clock);
    #1 chk("busy_start_ignored", product, 32'd12);

    issue(32'd5, 32'd5);
    repeat (29) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", product, 32'd0);
    repeat (80) @(posedge clock);
    #1 chk("abort_no_done_busy", {31'd0, busy}, 32'd0);
    issue(32'd2, 32'd3);
    wait_idle();
    chk("after_abort_6", product, 32'd6);

    gnt_mode = 1;
    for (int i = 0; i < N_RAND; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, ra[15:0]};
      issue(ra, rb);
    end
    wait_idle();
    gnt_mode = 0;
    repeat (4) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
